// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array input stages: default geometry,
// the MSB-first column slice offset, and the {valid, data} stage element.
package sa_pkg;

  localparam int COL_DEFAULT    = 3;
  localparam int W_DATA_DEFAULT = 8;

  typedef struct packed {
    logic                      valid;
    logic [W_DATA_DEFAULT-1:0] data;
  } stage_t;

  // Column 0 is the most significant slice of a packed row vector.
  function automatic int col_slice_msb(input int col, input int w_data, input int idx);
    return w_data * (col - idx) - 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One column of the skew stage: DEPTH registered stages of {valid, side, data},
// advancing only while i_en is high; data is captured only alongside a valid.
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int W_DATA = 8,
  parameter int W_SIDE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [W_DATA-1:0] i_data,
  input  logic [W_SIDE-1:0] i_side,
  output logic              o_valid,
  output logic [W_DATA-1:0] o_data,
  output logic [W_SIDE-1:0] o_side,
  output logic              o_any_valid
);

  logic [DEPTH-1:0]  r_valid;
  logic [W_SIDE-1:0] r_side [DEPTH];
  logic [W_DATA-1:0] r_data [DEPTH];

  // NOTE: the data stages are reset along with valid/side so that o_data reads
  // a defined 0 after reset instead of X; this is a short shift line, not a RAM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_side[k] <= '0;
        r_data[k] <= '0;
      end
    end else if (i_en) begin
      r_valid[0] <= i_valid;
      r_side[0]  <= i_side;
      if (i_valid) r_data[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_side[k]  <= r_side[k-1];
        // Bubbles leave data untouched, so invalid slots keep the last valid value.
        if (r_valid[k-1]) r_data[k] <= r_data[k-1];
      end
    end
  end

  assign o_valid     = r_valid[DEPTH-1];
  assign o_data      = r_data[DEPTH-1];
  assign o_side      = r_side[DEPTH-1];
  assign o_any_valid = |r_valid;

endmodule

// File: rtl/in_sa_column_skew.sv
// Input skew stage: delays column i by i extra cycles and tracks tile count/busy/done.
// Optional macro SA_SKEW_ZERO_FILL_EN forces invalid output slices to zero.
module in_sa_column_skew
  import sa_pkg::*;
#(
  parameter int COL    = COL_DEFAULT,
  parameter int W_DATA = W_DATA_DEFAULT,
  parameter int W_CNT  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [COL*W_DATA-1:0] i_data,
  input  logic                  i_dv,
  input  logic                  i_last,
  input  logic                  i_stall,
  output logic                  o_ready,
  output logic [COL*W_DATA-1:0] o_data,
  output logic [COL-1:0]        o_dv,
  output logic                  o_busy,
  output logic [W_CNT-1:0]      o_count,
  output logic                  o_done
);

  logic             w_run;
  logic             w_accept;
  logic [COL-1:0]   w_col_valid;
  logic [COL-1:0]   w_col_side;
  logic [COL-1:0]   w_col_any;
  logic             w_unused_side;
  logic [W_CNT-1:0] r_count;

  assign w_run    = ~i_stall;
  assign w_accept = i_dv & w_run;

  for (genvar gi = 0; gi < COL; gi++) begin : g_col
    localparam int MSB = col_slice_msb(COL, W_DATA, gi);
    logic [W_DATA-1:0] w_line_data;
    logic              w_side_in;

    // Only the last column carries the tile-last marker.
    assign w_side_in = (gi == COL - 1) ? (i_last & w_accept) : 1'b0;

    skew_delay_line #(
      .DEPTH (gi + 1),
      .W_DATA(W_DATA),
      .W_SIDE(1)
    ) u_line (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (w_run),
      .i_valid    (w_accept),
      .i_data     (i_data[MSB -: W_DATA]),
      .i_side     (w_side_in),
      .o_valid    (w_col_valid[gi]),
      .o_data     (w_line_data),
      .o_side     (w_col_side[gi]),
      .o_any_valid(w_col_any[gi])
    );

`ifdef SA_SKEW_ZERO_FILL_EN
    assign o_data[MSB -: W_DATA] = o_dv[gi] ? w_line_data : '0;
`else
    assign o_data[MSB -: W_DATA] = w_line_data;
`endif
  end

  assign w_unused_side = ^w_col_side;

  assign o_ready = w_run;
  assign o_dv    = w_col_valid & {COL{w_run}};
  assign o_busy  = |w_col_any;
  // A stalled done cycle is simply held in the last stage until the stall drops.
  assign o_done  = w_col_valid[COL-1] & w_col_side[COL-1] & w_run;
  assign o_count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (w_run) begin
      if (o_done)
        r_count <= w_accept ? W_CNT'(1) : '0;
      else if (w_accept && r_count != '1)
        r_count <= r_count + W_CNT'(1);
    end
  end

endmodule
